// File: rtl/riscv_pkg.sv
// Shared core-wide constants for the register-file scoreboard slice.
package riscv_pkg;

    localparam int RV_XLEN       = 32;
    localparam int SB_TAG_WIDTH  = 3;
    localparam int REG_ADDR_W    = 5;
    localparam int NUM_ARCH_REGS = 32;

    function automatic logic is_x0(input logic [REG_ADDR_W-1:0] addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/sb_fwd_select.sv
// Priority forward mux for one read port: lowest fwd index wins, writeback is the last resort.
module sb_fwd_select
    import riscv_pkg::*;
#(
    parameter int NUM_FWD   = 3,
    parameter int TAG_WIDTH = SB_TAG_WIDTH,
    parameter int XLEN      = RV_XLEN
) (
    input  logic [REG_ADDR_W-1:0]         rd_addr,
    input  logic [TAG_WIDTH-1:0]          owner_tag,
    input  logic [NUM_FWD-1:0]            fwd_en,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_addr,
    input  logic [NUM_FWD*TAG_WIDTH-1:0]  fwd_tag,
    input  logic [NUM_FWD*XLEN-1:0]       fwd_data,
    input  logic                          wb_en,
    input  logic [REG_ADDR_W-1:0]         wb_addr,
    input  logic [TAG_WIDTH-1:0]          wb_tag,
    input  logic [XLEN-1:0]               wb_data,
    output logic                          hit,
    output logic [XLEN-1:0]               data
);

    logic [NUM_FWD-1:0] src_match;
    logic               wb_match;

    for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_src
        assign src_match[gi] = fwd_en[gi]
                            && (fwd_addr[gi*REG_ADDR_W +: REG_ADDR_W] == rd_addr)
                            && (fwd_tag[gi*TAG_WIDTH +: TAG_WIDTH] == owner_tag);
    end

    assign wb_match = wb_en && (wb_addr == rd_addr) && (wb_tag == owner_tag);

    // Scan from the oldest source down so the youngest match overwrites last.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        if (wb_match) begin
            hit  = 1'b1;
            data = wb_data;
        end
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (src_match[i]) begin
                hit  = 1'b1;
                data = fwd_data[i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/rf_tag_scoreboard.sv
// Register file with per-register writer tags; resolves operands from RF, forwarding or writeback.
module rf_tag_scoreboard
    import riscv_pkg::*;
#(
    parameter int NUM_RD    = 2,
    parameter int NUM_FWD   = 3,
    parameter int TAG_WIDTH = SB_TAG_WIDTH,
    parameter int XLEN      = RV_XLEN
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_RD-1:0]             rd_en,
    input  logic [NUM_RD*REG_ADDR_W-1:0]  rd_addr,
    output logic [NUM_RD*XLEN-1:0]        rd_data,
    output logic [NUM_RD-1:0]             rd_valid,
    input  logic                          alloc_en,
    input  logic [REG_ADDR_W-1:0]         alloc_addr,
    output logic [TAG_WIDTH-1:0]          alloc_tag,
    output logic                          alloc_ready,
    input  logic [NUM_FWD-1:0]            fwd_en,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_addr,
    input  logic [NUM_FWD*TAG_WIDTH-1:0]  fwd_tag,
    input  logic [NUM_FWD*XLEN-1:0]       fwd_data,
    input  logic                          wb_en,
    input  logic [REG_ADDR_W-1:0]         wb_addr,
    input  logic [TAG_WIDTH-1:0]          wb_tag,
    input  logic [XLEN-1:0]               wb_data,
    input  logic                          flush,
    output logic [TAG_WIDTH:0]            inflight_cnt
);

    // One tag is always held back so a live tag is never handed out twice.
    localparam logic [TAG_WIDTH:0] INFLIGHT_MAX = (TAG_WIDTH+1)'((1 << TAG_WIDTH) - 1);

    logic [XLEN-1:0]          rf_reg  [NUM_ARCH_REGS];
    logic [TAG_WIDTH-1:0]     tag_reg [NUM_ARCH_REGS];
    logic [NUM_ARCH_REGS-1:0] dirty_reg;
    logic [TAG_WIDTH-1:0]     next_tag_reg;
    logic [TAG_WIDTH:0]       inflight_reg;
    logic [TAG_WIDTH:0]       inflight_next;
    logic [TAG_WIDTH:0]       inflight_inc;
    logic                     alloc_fire;
    logic                     wb_owner_match;

    assign alloc_ready    = (inflight_reg < INFLIGHT_MAX) && !flush;
    assign alloc_fire     = alloc_en && alloc_ready;
    assign alloc_tag      = next_tag_reg;
    assign inflight_cnt   = inflight_reg;
    assign wb_owner_match = wb_en && (wb_tag == tag_reg[wb_addr]);

    // Allocate before retiring so a same-cycle pair nets to zero instead of saturating.
    always_comb begin
        inflight_inc  = inflight_reg + (TAG_WIDTH+1)'(alloc_fire);
        inflight_next = inflight_inc;
        if (wb_en && (inflight_inc != '0)) begin
            inflight_next = inflight_inc - (TAG_WIDTH+1)'(1);
        end
        if (flush) begin
            inflight_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                rf_reg[i]  <= '0;
                tag_reg[i] <= '0;
            end
            dirty_reg    <= '0;
            next_tag_reg <= '0;
            inflight_reg <= '0;
        end else begin
            if (wb_en && !is_x0(wb_addr)) begin
                rf_reg[wb_addr] <= wb_data;
            end
            if (flush) begin
                dirty_reg <= '0;
            end else begin
                // A stale-tag writeback must not release a register claimed by a younger writer.
                if (wb_owner_match) begin
                    dirty_reg[wb_addr] <= 1'b0;
                end
                if (alloc_fire && !is_x0(alloc_addr)) begin
                    dirty_reg[alloc_addr] <= 1'b1;
                    tag_reg[alloc_addr]   <= next_tag_reg;
                end
            end
            if (alloc_fire) begin
                next_tag_reg <= next_tag_reg + TAG_WIDTH'(1);
            end
            inflight_reg <= inflight_next;
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [REG_ADDR_W-1:0] port_addr;
        logic                  fwd_hit;
        logic [XLEN-1:0]       fwd_val;
        logic                  port_x0;
        logic                  port_dirty;

        assign port_addr  = rd_addr[gi*REG_ADDR_W +: REG_ADDR_W];
        assign port_x0    = is_x0(port_addr);
        assign port_dirty = dirty_reg[port_addr];

        sb_fwd_select #(
            .NUM_FWD   (NUM_FWD),
            .TAG_WIDTH (TAG_WIDTH),
            .XLEN      (XLEN)
        ) u_fwd_select (
            .rd_addr   (port_addr),
            .owner_tag (tag_reg[port_addr]),
            .fwd_en    (fwd_en),
            .fwd_addr  (fwd_addr),
            .fwd_tag   (fwd_tag),
            .fwd_data  (fwd_data),
            .wb_en     (wb_en),
            .wb_addr   (wb_addr),
            .wb_tag    (wb_tag),
            .wb_data   (wb_data),
            .hit       (fwd_hit),
            .data      (fwd_val)
        );

        assign rd_valid[gi] = !rd_en[gi] || port_x0 || !port_dirty || fwd_hit;
        assign rd_data[gi*XLEN +: XLEN] =
            (!rd_en[gi] || port_x0) ? '0 :
            !port_dirty             ? rf_reg[port_addr] :
            fwd_hit                 ? fwd_val : '0;
    end

endmodule

// File: tb/tb_rf_tag_scoreboard.sv
// Directed scenarios plus randomized traffic checked against an array-based scoreboard model.
module tb_rf_tag_scoreboard;

    localparam int NRD = 2;
    localparam int NFW = 3;
    localparam int TW  = 3;
    localparam int XL  = 32;
    localparam int MAX_LIVE = (1 << TW) - 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NRD-1:0]    rd_en;
    logic [NRD*5-1:0]  rd_addr;
    logic [NRD*XL-1:0] rd_data;
    logic [NRD-1:0]    rd_valid;
    logic              alloc_en;
    logic [4:0]        alloc_addr;
    logic [TW-1:0]     alloc_tag;
    logic              alloc_ready;
    logic [NFW-1:0]    fwd_en;
    logic [NFW*5-1:0]  fwd_addr;
    logic [NFW*TW-1:0] fwd_tag;
    logic [NFW*XL-1:0] fwd_data;
    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [TW-1:0]     wb_tag;
    logic [XL-1:0]     wb_data;
    logic              flush;
    logic [TW:0]       inflight_cnt;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    // Scoreboard model state
    logic [XL-1:0] m_rf    [32];
    bit            m_dirty [32];
    int            m_owner [32];
    int            m_next_tag;
    int            m_inflight;

    rf_tag_scoreboard #(
        .NUM_RD(NRD), .NUM_FWD(NFW), .TAG_WIDTH(TW), .XLEN(XL)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_tag(alloc_tag),
        .alloc_ready(alloc_ready),
        .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_tag(fwd_tag), .fwd_data(fwd_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_tag(wb_tag), .wb_data(wb_data),
        .flush(flush), .inflight_cnt(inflight_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (txn %0d)", tag, got, exp, txn);
        end
    endtask

    task automatic set_idle();
        rd_en = '0; rd_addr = '0;
        alloc_en = 1'b0; alloc_addr = '0;
        fwd_en = '0; fwd_addr = '0; fwd_tag = '0; fwd_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_tag = '0; wb_data = '0;
        flush = 1'b0;
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) begin
            m_rf[i] = '0; m_dirty[i] = 1'b0; m_owner[i] = 0;
        end
        m_next_tag = 0;
        m_inflight = 0;
    endfunction

    function automatic bit m_ready();
        return (m_inflight < MAX_LIVE) && !flush;
    endfunction

    // Operand rules: x0, clean RF, youngest matching forward, matching writeback, else not ready.
    function automatic void m_read(input int p, output bit v, output logic [XL-1:0] d);
        int a;
        a = int'(rd_addr[p*5 +: 5]);
        v = 1'b0; d = '0;
        if (!rd_en[p] || a == 0) begin
            v = 1'b1;
        end else if (!m_dirty[a]) begin
            v = 1'b1; d = m_rf[a];
        end else begin
            for (int i = 0; i < NFW; i++) begin
                if (!v && fwd_en[i] && int'(fwd_addr[i*5 +: 5]) == a
                        && int'(fwd_tag[i*TW +: TW]) == m_owner[a]) begin
                    v = 1'b1; d = fwd_data[i*XL +: XL];
                end
            end
            if (!v && wb_en && int'(wb_addr) == a && int'(wb_tag) == m_owner[a]) begin
                v = 1'b1; d = wb_data;
            end
        end
    endfunction

    function automatic void m_update();
        bit fire;
        int cnt;
        fire = alloc_en && m_ready();
        if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
        if (flush) begin
            for (int i = 0; i < 32; i++) m_dirty[i] = 1'b0;
            m_inflight = 0;
        end else begin
            if (wb_en && int'(wb_tag) == m_owner[wb_addr]) m_dirty[wb_addr] = 1'b0;
            if (fire && alloc_addr != 0) begin
                m_dirty[alloc_addr] = 1'b1;
                m_owner[alloc_addr] = m_next_tag;
            end
            cnt = m_inflight + (fire ? 1 : 0);
            if (wb_en && cnt > 0) cnt--;
            m_inflight = cnt;
        end
        if (fire) m_next_tag = (m_next_tag + 1) % (1 << TW);
    endfunction

    task automatic check_outputs();
        bit            v;
        logic [XL-1:0] d;
        check_eq("alloc_ready", 64'(alloc_ready), 64'(m_ready()));
        check_eq("alloc_tag", 64'(alloc_tag), 64'(m_next_tag));
        check_eq("inflight_cnt", 64'(inflight_cnt), 64'(m_inflight));
        for (int p = 0; p < NRD; p++) begin
            m_read(p, v, d);
            check_eq($sformatf("rd_valid%0d", p), 64'(rd_valid[p]), 64'(v));
            if (rd_en[p]) check_eq($sformatf("rd_data%0d", p), 64'(rd_data[p*XL +: XL]), 64'(d));
        end
    endtask

    // Inputs are always driven 1 time unit after a rising edge.
    task automatic settle();
        #4;
        check_outputs();
    endtask

    task automatic tick();
        @(posedge clk);
        m_update();
        txn++;
        $display("txn %0d alloc=%0b@x%0d wb=%0b@x%0d/t%0d flush=%0b rd_valid=%b inflight=%0d",
                 txn, alloc_en, alloc_addr, wb_en, wb_addr, wb_tag, flush, rd_valid, inflight_cnt);
        #1;
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    task automatic do_alloc(input int a);
        set_idle();
        alloc_en = 1'b1; alloc_addr = 5'(a);
        cycle();
    endtask

    task automatic do_wb(input int a, input int t, input logic [XL-1:0] d);
        set_idle();
        wb_en = 1'b1; wb_addr = 5'(a); wb_tag = TW'(t); wb_data = d;
        cycle();
    endtask

    // Reset lands mid-cycle with alloc/wb active; x9 on port 0 must read 0/valid at once.
    task automatic apply_reset();
        set_idle();
        alloc_en = 1'b1; alloc_addr = 5'd3;
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'hCAFE_F00D;
        rd_en = 2'b11; rd_addr = {5'd4, 5'd9};
        #1;
        reset_n = 1'b0;
        m_reset();
        #1;
        check_eq("rst_x9_valid", 64'(rd_valid[0]), 64'd1);
        check_eq("rst_x9_data", 64'(rd_data[XL-1:0]), 64'd0);
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        reset_n = 1'b1;
        set_idle();
    endtask

    function automatic logic [4:0] pick_addr();
        if ($urandom % 8 == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 8));
    endfunction

    task automatic random_cycle();
        logic [4:0] a;
        set_idle();
        alloc_en   = ($urandom % 2) == 0;
        alloc_addr = pick_addr();
        wb_en      = ($urandom % 3) == 0;
        wb_addr    = pick_addr();
        wb_tag     = ($urandom % 2) ? TW'(m_owner[wb_addr]) : TW'($urandom);
        wb_data    = $urandom;
        flush      = ($urandom % 32) == 0;
        for (int i = 0; i < NFW; i++) begin
            a = pick_addr();
            fwd_en[i] = ($urandom % 3) == 0;
            fwd_addr[i*5 +: 5] = a;
            fwd_tag[i*TW +: TW] = ($urandom % 4 != 0) ? TW'(m_owner[a]) : TW'($urandom);
            fwd_data[i*XL +: XL] = $urandom;
        end
        for (int p = 0; p < NRD; p++) begin
            rd_en[p] = ($urandom % 4) != 0;
            rd_addr[p*5 +: 5] = pick_addr();
        end
        cycle();
    endtask

    initial begin
        reset_n = 1'b0;
        set_idle();
        m_reset();
        #2;
        check_outputs();
        @(posedge clk);
        #1;
        apply_reset();

        // Pending operand, then picked up from forward source 1
        set_idle();
        alloc_en = 1'b1; alloc_addr = 5'd5;
        settle();
        check_eq("d42_alloc_tag", 64'(alloc_tag), 64'd0);
        tick();
        set_idle();
        rd_en = 2'b01; rd_addr = 10'd5;
        settle();
        check_eq("d42_pend_valid", 64'(rd_valid[0]), 64'd0);
        tick();
        fwd_en = 3'b010; fwd_addr = {5'd0, 5'd5, 5'd0}; fwd_tag = '0;
        fwd_data = {32'h0, 32'h1234, 32'h0};
        settle();
        check_eq("d42_fwd_valid", 64'(rd_valid[0]), 64'd1);
        check_eq("d42_fwd_data", 64'(rd_data[XL-1:0]), 64'h1234);
        tick();

        // Stale writeback must not clear the newer owner
        apply_reset();
        do_alloc(5);
        do_alloc(5);
        set_idle();
        wb_en = 1'b1; wb_addr = 5'd5; wb_tag = 3'd0; wb_data = 32'h55;
        rd_en = 2'b01; rd_addr = 10'd5;
        settle();
        check_eq("d43_stale_wb_valid", 64'(rd_valid[0]), 64'd0);
        tick();
        set_idle();
        rd_en = 2'b01; rd_addr = 10'd5;
        settle();
        check_eq("d43_still_dirty", 64'(rd_valid[0]), 64'd0);
        check_eq("d43_inflight", 64'(inflight_cnt), 64'd1);
        tick();
        fwd_en = 3'b100; fwd_addr = {5'd5, 5'd0, 5'd0}; fwd_tag = {3'd1, 3'd0, 3'd0};
        fwd_data = {32'h77, 32'h0, 32'h0};
        settle();
        check_eq("d43_fwd_data", 64'(rd_data[XL-1:0]), 64'h77);
        tick();
        set_idle();
        wb_en = 1'b1; wb_addr = 5'd5; wb_tag = 3'd1; wb_data = 32'h99;
        rd_en = 2'b01; rd_addr = 10'd5;
        settle();
        check_eq("d43_wb_bypass", 64'(rd_data[XL-1:0]), 64'h99);
        tick();
        set_idle();
        rd_en = 2'b01; rd_addr = 10'd5;
        settle();
        check_eq("d43_rf_data", 64'(rd_data[XL-1:0]), 64'h99);
        tick();

        // Forward priority: source 0 beats source 2
        apply_reset();
        do_alloc(7);
        set_idle();
        fwd_en = 3'b101; fwd_addr = {5'd7, 5'd7, 5'd7}; fwd_tag = '0;
        fwd_data = {32'hB, 32'hC, 32'hA};
        rd_en = 2'b11; rd_addr = {5'd7, 5'd7};
        settle();
        check_eq("d44_prio_p0", 64'(rd_data[XL-1:0]), 64'hA);
        check_eq("d44_prio_p1", 64'(rd_data[2*XL-1:XL]), 64'hA);
        tick();

        // Tag exhaustion
        apply_reset();
        for (int i = 1; i <= MAX_LIVE; i++) do_alloc(i);
        set_idle();
        alloc_en = 1'b1; alloc_addr = 5'd8;
        settle();
        check_eq("d45_full_ready", 64'(alloc_ready), 64'd0);
        check_eq("d45_full_cnt", 64'(inflight_cnt), 64'd7);
        tick();
        do_wb(1, 0, 32'h11);
        set_idle();
        settle();
        check_eq("d45_after_wb_ready", 64'(alloc_ready), 64'd1);
        check_eq("d45_after_wb_tag", 64'(alloc_tag), 64'd7);
        tick();

        // Flush
        apply_reset();
        for (int i = 1; i <= 3; i++) do_alloc(i);
        set_idle();
        flush = 1'b1; alloc_en = 1'b1; alloc_addr = 5'd4;
        settle();
        check_eq("d46_flush_ready", 64'(alloc_ready), 64'd0);
        tick();
        set_idle();
        rd_en = 2'b11; rd_addr = {5'd2, 5'd1};
        settle();
        check_eq("d46_cnt", 64'(inflight_cnt), 64'd0);
        check_eq("d46_valid", 64'(rd_valid), 64'd3);
        check_eq("d46_next_tag", 64'(alloc_tag), 64'd3);
        tick();

        // Reset with a dirty x9 holding data
        do_wb(9, 0, 32'hDEAD);
        do_alloc(9);
        set_idle();
        rd_en = 2'b01; rd_addr = 10'd9;
        settle();
        check_eq("d47_pre_valid", 64'(rd_valid[0]), 64'd0);
        tick();
        apply_reset();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom % 150 == 0) apply_reset();
            random_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
